// File: rtl/imem_responder_if.sv
// Fetch and loader signal bundle for imem_responder.
// master: fetch stage / program loader side. slave: the responder.
// fetch_err_o exists only when IMEM_MISALIGN_TRAP_EN is defined.
interface imem_responder_if #(
  parameter int AW = 10
);
  // Fetch port
  logic [31:0] iaddr_i;
  logic        ird_i;
  logic [31:0] irdata_o;
  // Streaming loader port
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;
  // Status
  logic        run_o;
  logic [AW:0] ld_count_o;
  logic        ld_ovf_o;
`ifdef IMEM_MISALIGN_TRAP_EN
  logic        fetch_err_o;
`endif

  modport master (
    output iaddr_i, ird_i, ld_valid_i, ld_data_i, ld_last_i,
    input  irdata_o, ld_ready_o, run_o, ld_count_o, ld_ovf_o
`ifdef IMEM_MISALIGN_TRAP_EN
    , input fetch_err_o
`endif
  );

  modport slave (
    input  iaddr_i, ird_i, ld_valid_i, ld_data_i, ld_last_i,
    output irdata_o, ld_ready_o, run_o, ld_count_o, ld_ovf_o
`ifdef IMEM_MISALIGN_TRAP_EN
    , output fetch_err_o
`endif
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder for the stage1 fetch port.
// After reset the array is filled through a streaming loader (LOAD state);
// the final loader word moves the block to RUN, where fetches are served
// with one cycle of latency. irdata_o holds between accepted fetches.
// Optional feature: define IMEM_MISALIGN_TRAP_EN to return 32'h0 and pulse
// fetch_err_o for misaligned fetches in RUN.
module imem_responder #(
  parameter int          DEPTH    = 1024,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input logic             clk_i,
  input logic             reset_i,
  imem_responder_if.slave bus
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [31:0]   mem [DEPTH];
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic [31:0]   irdata_q;

  logic          in_run;
  logic          ld_fire;
  logic          ld_write;
  logic          ld_drop;
  logic          out_of_range;
  logic [AW-1:0] fetch_idx;

  assign in_run       = (state_q == S_RUN);
  assign ld_fire      = bus.ld_valid_i & ~in_run;
  assign ld_write     = ld_fire & (count_q < DEPTH_CNT);
  assign ld_drop      = ld_fire & (count_q == DEPTH_CNT);
  assign out_of_range = ((bus.iaddr_i >> (AW + 2)) != 32'd0);
  assign fetch_idx    = bus.iaddr_i[AW+1:2];

  // Next-state logic: the only transition is LOAD->RUN on the last loader word.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    if (state_q == S_LOAD && ld_fire && bus.ld_last_i) begin
      state_d = S_RUN;
    end
  end

  // State register; RUN is left only through reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential blocks use non-blocking '<=' so every register samples
    // pre-edge values regardless of statement or block ordering.
    if (reset_i) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Loader word counter (saturates at DEPTH) and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (ld_write) begin
        count_q <= count_q + 1'b1;
      end
      if (ld_drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Array write port, driven by the loader.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset so it maps onto RAM; contents survive a
    // reset and a partial reload only overwrites the words it reaches.
    if (ld_write) begin
      mem[count_q[AW-1:0]] <= bus.ld_data_i;
    end
  end

`ifdef IMEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic fetch_err_q;

  assign misaligned = (bus.iaddr_i[1:0] != 2'b00);

  // Error flag is high only in the cycle right after a misaligned RUN fetch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= bus.ird_i & in_run & ~out_of_range & misaligned;
    end
  end

  assign bus.fetch_err_o = fetch_err_q;
`else
  logic unused_ok;
  assign unused_ok = ^bus.iaddr_i[1:0];
`endif

  // Fetch read port: one-cycle latency, holds while ird_i is low.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      irdata_q <= NOP_WORD;
    end else if (bus.ird_i) begin
      if (!in_run || out_of_range) begin
        irdata_q <= NOP_WORD;
`ifdef IMEM_MISALIGN_TRAP_EN
      end else if (misaligned) begin
        irdata_q <= 32'h00000000;
`endif
      end else begin
        irdata_q <= mem[fetch_idx];
      end
    end
  end

  assign bus.irdata_o   = irdata_q;
  assign bus.ld_ready_o = ~in_run;
  assign bus.run_o      = in_run;
  assign bus.ld_count_o = count_q;
  assign bus.ld_ovf_o   = ovf_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder.
// Two instances: DEPTH=1024 (main load/fetch/reset flows) and DEPTH=4
// (overflow and out-of-range). Fetch expectations are queued when a fetch is
// issued and checked by per-instance monitors one cycle later; status outputs
// are checked directly. Inputs change on the falling edge.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk_i = 1'b0;
  logic reset_i;

  initial forever #5 clk_i = ~clk_i;

  imem_responder_if #(.AW(10)) bus_a ();
  imem_responder_if #(.AW(2))  bus_b ();

  imem_responder #(.DEPTH(1024)) dut_a (.clk_i(clk_i), .reset_i(reset_i), .bus(bus_a));
  imem_responder #(.DEPTH(4))    dut_b (.clk_i(clk_i), .reset_i(reset_i), .bus(bus_b));

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for instance A: a fetch sampled at this edge is due 1 step later.
  always @(posedge clk_i) begin : mon_a
    exp_t e;
    if (bus_a.ird_i === 1'b1 && reset_i === 1'b0) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_unexpected_fetch: got fetch with empty queue expected none");
      end else begin
        e = q_a.pop_front();
        #1;
        check("a_irdata", bus_a.irdata_o, e.data);
`ifdef IMEM_MISALIGN_TRAP_EN
        check("a_fetch_err", 32'(bus_a.fetch_err_o), 32'(e.err));
`endif
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(posedge clk_i) begin : mon_b
    exp_t e;
    if (bus_b.ird_i === 1'b1 && reset_i === 1'b0) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_unexpected_fetch: got fetch with empty queue expected none");
      end else begin
        e = q_b.pop_front();
        #1;
        check("b_irdata", bus_b.irdata_o, e.data);
`ifdef IMEM_MISALIGN_TRAP_EN
        check("b_fetch_err", 32'(bus_b.fetch_err_o), 32'(e.err));
`endif
      end
    end
  end

  task automatic do_reset(input int cycles);
    reset_i = 1'b1;
    repeat (cycles) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic load(input bit b, input logic [31:0] d, input logic last);
    if (b) begin
      bus_b.ld_valid_i = 1'b1; bus_b.ld_data_i = d; bus_b.ld_last_i = last;
    end else begin
      bus_a.ld_valid_i = 1'b1; bus_a.ld_data_i = d; bus_a.ld_last_i = last;
    end
    @(negedge clk_i);
    bus_a.ld_valid_i = 1'b0; bus_a.ld_last_i = 1'b0;
    bus_b.ld_valid_i = 1'b0; bus_b.ld_last_i = 1'b0;
  endtask

  task automatic fetch(input bit b, input logic [31:0] addr, input logic [31:0] d, input logic err);
    exp_t e;
    e.data = d;
    e.err  = err;
    if (b) begin
      q_b.push_back(e); bus_b.iaddr_i = addr; bus_b.ird_i = 1'b1;
    end else begin
      q_a.push_back(e); bus_a.iaddr_i = addr; bus_a.ird_i = 1'b1;
    end
    @(negedge clk_i);
    bus_a.ird_i = 1'b0;
    bus_b.ird_i = 1'b0;
  endtask

  task automatic status(input bit b, input string tag, input int cnt,
                        input logic run, input logic ovf);
    if (b) begin
      check({tag, "_count"}, 32'(bus_b.ld_count_o), 32'(cnt));
      check({tag, "_run"},   32'(bus_b.run_o),      32'(run));
      check({tag, "_ready"}, 32'(bus_b.ld_ready_o), 32'(!run));
      check({tag, "_ovf"},   32'(bus_b.ld_ovf_o),   32'(ovf));
    end else begin
      check({tag, "_count"}, 32'(bus_a.ld_count_o), 32'(cnt));
      check({tag, "_run"},   32'(bus_a.run_o),      32'(run));
      check({tag, "_ready"}, 32'(bus_a.ld_ready_o), 32'(!run));
      check({tag, "_ovf"},   32'(bus_a.ld_ovf_o),   32'(ovf));
    end
  endtask

  // Watchdog: the directed flow has no open-ended waits, but never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] PROG [4] = '{32'h00500093, 32'h00108113, 32'h00000063, 32'h0000006F};
  localparam logic [31:0] NEWP [4] = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
  localparam logic [31:0] SMALL[6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};

  initial begin
    reset_i = 1'b1;
    bus_a.iaddr_i = '0; bus_a.ird_i = 1'b0;
    bus_a.ld_valid_i = 1'b0; bus_a.ld_data_i = '0; bus_a.ld_last_i = 1'b0;
    bus_b.iaddr_i = '0; bus_b.ird_i = 1'b0;
    bus_b.ld_valid_i = 1'b0; bus_b.ld_data_i = '0; bus_b.ld_last_i = 1'b0;

    // ---- Reset values ----
    do_reset(2);
    check("a_reset_irdata", bus_a.irdata_o, NOP);
    status(0, "a_reset", 0, 1'b0, 1'b0);
`ifdef IMEM_MISALIGN_TRAP_EN
    check("a_reset_err", 32'(bus_a.fetch_err_o), 32'd0);
`endif

    // ---- Fetch during LOAD returns NOP ----
    fetch(0, 32'h4, NOP, 1'b0);

    // ---- Load 4 words, last on the 4th ----
    for (int i = 0; i < 3; i++) load(0, PROG[i], 1'b0);
    status(0, "a_load3", 3, 1'b0, 1'b0);
    load(0, PROG[3], 1'b1);
    status(0, "a_loaded", 4, 1'b1, 1'b0);

    // ---- Fetches in RUN ----
    fetch(0, 32'h8, 32'h00000063, 1'b0);
    fetch(0, 32'h4, 32'h00108113, 1'b0);
    fetch(0, 32'hC, 32'h0000006F, 1'b0);
    fetch(0, 32'h1000, NOP, 1'b0);
    fetch(0, 32'h8000_0000, NOP, 1'b0);

    // ---- Misaligned fetch ----
`ifdef IMEM_MISALIGN_TRAP_EN
    fetch(0, 32'h6, 32'h00000000, 1'b1);
    @(negedge clk_i);
    check("a_err_pulse_end", 32'(bus_a.fetch_err_o), 32'd0);
`else
    fetch(0, 32'h6, 32'h00108113, 1'b0);
    fetch(0, 32'h9, 32'h00000063, 1'b0);
`endif

    // ---- Hold while ird_i low and iaddr_i changes ----
    fetch(0, 32'h0, 32'h00500093, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      bus_a.iaddr_i = 32'(i * 4);
      @(negedge clk_i);
      check("a_hold", bus_a.irdata_o, 32'h00500093);
    end

    // ---- Loader ignored in RUN ----
    load(0, 32'hDEADBEEF, 1'b1);
    status(0, "a_run_ignore", 4, 1'b1, 1'b0);
    fetch(0, 32'h0, 32'h00500093, 1'b0);

    // ---- Reset in RUN ----
    do_reset(1);
    check("a_rst_run_irdata", bus_a.irdata_o, NOP);
    status(0, "a_rst_run", 0, 1'b0, 1'b0);

    // ---- Reset mid-load, then reload ----
    load(0, NEWP[0], 1'b0);
    load(0, NEWP[1], 1'b0);
    status(0, "a_partial", 2, 1'b0, 1'b0);
    fetch(0, 32'h0, NOP, 1'b0);
    do_reset(1);
    status(0, "a_rst_mid", 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) load(0, NEWP[i], i == 3);
    status(0, "a_reload", 4, 1'b1, 1'b0);
    fetch(0, 32'h0, NEWP[0], 1'b0);
    fetch(0, 32'hC, NEWP[3], 1'b0);

    // ---- DEPTH=4 overflow ----
    do_reset(1);
    status(1, "b_reset", 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) load(1, SMALL[i], 1'b0);
    status(1, "b_full", 4, 1'b0, 1'b0);
    load(1, SMALL[4], 1'b0);
    status(1, "b_ovf", 4, 1'b0, 1'b1);
    load(1, SMALL[5], 1'b1);
    status(1, "b_ovf_run", 4, 1'b1, 1'b1);
    fetch(1, 32'h10, NOP, 1'b0);
    fetch(1, 32'hC, 32'h44, 1'b0);
    fetch(1, 32'h0, 32'h11, 1'b0);
    do_reset(1);
    status(1, "b_ovf_clear", 0, 1'b0, 1'b0);

    // ---- Drain ----
    repeat (2) @(negedge clk_i);
    check("a_queue_empty", 32'(q_a.size()), 32'd0);
    check("b_queue_empty", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
